// File: rtl/imm_pkg.sv
// Shared definitions for the immediate decode unit.
//   fmt_e  : detected instruction format code (driven on FMT)
//   occ_e  : occupancy of the output/skid buffer pair
//   OP_*   : RV32I/RV64I major opcodes recognised by the extractor
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_Z   = 3'd6,
      FMT_ILL = 3'd7
   } fmt_e;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_extract.sv
// Combinational format detection and immediate extraction.
// Ports:
//   instruct : 32-bit instruction word
//   imm      : immediate, sign-extended (zero-extended for Z) to XLEN
//   fmt      : detected format
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instruct,
   output logic [XLEN-1:0] imm,
   output fmt_e            fmt
);

   // Every format's immediate fits in 32 bits, so build it at 32 bits
   // already extended and then widen by sign. Z has bit 31 clear, so the
   // final sign extension leaves it zero-extended.
   logic [31:0] imm32;

   always_comb begin
      fmt = FMT_ILL;
      case (instruct[6:0])
         OP_LUI, OP_AUIPC:                     fmt = FMT_U;
         OP_JAL:                               fmt = FMT_J;
         OP_JALR, OP_LOAD, OP_OPIMM, OP_FENCE: fmt = FMT_I;
         OP_BRANCH:                            fmt = FMT_B;
         OP_STORE:                             fmt = FMT_S;
         OP_OP:                                fmt = FMT_R;
         OP_SYSTEM:                            fmt = instruct[14] ? FMT_Z : FMT_I;
         default:                              fmt = FMT_ILL;
      endcase
   end

   always_comb begin
      imm32 = 32'd0;
      case (fmt)
         FMT_I: imm32 = {{20{instruct[31]}}, instruct[31:20]};
         FMT_S: imm32 = {{20{instruct[31]}}, instruct[31:25], instruct[11:7]};
         FMT_B: imm32 = {{19{instruct[31]}}, instruct[31], instruct[7],
                         instruct[30:25], instruct[11:8], 1'b0};
         FMT_J: imm32 = {{11{instruct[31]}}, instruct[31], instruct[19:12],
                         instruct[20], instruct[30:21], 1'b0};
         FMT_U: imm32 = {instruct[31:12], 12'd0};
         FMT_Z: imm32 = {27'd0, instruct[19:15]};
         default: imm32 = 32'd0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_unit.sv
// Immediate decode unit with valid/ready handshake on both sides.
// An accepted instruction is decoded at the input side and lands in the
// output register one cycle later; a single skid register absorbs one
// extra entry when the consumer stalls, so IN_READY can be a flop.
//
//   state     | meaning
//   ----------+------------------------------------------
//   OCC_EMPTY | no entry held, OUT_VALID=0
//   OCC_ONE   | output register valid, skid empty
//   OCC_FULL  | output and skid valid, input blocked
//
// Ports:
//   CLK, RST             : clock, asynchronous active-high reset
//   IN_VALID/IN_READY    : input handshake (INSTRUCT, PC)
//   OUT_VALID/OUT_READY  : output handshake (IMM, FMT, TARGET, ILLEGAL)
//   TARGET               : PC + IMM modulo 2^XLEN (0 when TARGET_EN=0)
module imm_decode_unit
   import imm_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit TARGET_EN = 1'b1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            IN_VALID,
   output logic            IN_READY,
   input  logic [31:0]     INSTRUCT,
   input  logic [XLEN-1:0] PC,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [XLEN-1:0] IMM,
   output logic [2:0]      FMT,
   output logic [XLEN-1:0] TARGET,
   output logic            ILLEGAL
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      fmt_e            fmt;
      logic            ill;
   } entry_t;

   localparam entry_t ENTRY_RST = '{imm: '0, target: '0, fmt: FMT_R, ill: 1'b0};

   logic [XLEN-1:0] ext_imm;
   fmt_e            ext_fmt;
   entry_t          in_entry;

   occ_e   state_q, state_d;
   entry_t out_q, out_d;
   entry_t skid_q, skid_d;
   logic   in_ready_q, in_ready_d;
   logic   push, pop;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instruct (INSTRUCT),
      .imm      (ext_imm),
      .fmt      (ext_fmt)
   );

   always_comb begin
      in_entry.imm    = ext_imm;
      in_entry.target = TARGET_EN ? (PC + ext_imm) : '0;
      in_entry.fmt    = ext_fmt;
      in_entry.ill    = (ext_fmt == FMT_ILL);
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      push    = IN_VALID && in_ready_q;
      pop     = (state_q != OCC_EMPTY) && OUT_READY;
      case (state_q)
         OCC_EMPTY: begin
            if (push) begin
               out_d   = in_entry;
               state_d = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (push && pop) begin
               out_d = in_entry;
            end else if (push) begin
               skid_d  = in_entry;
               state_d = OCC_FULL;
            end else if (pop) begin
               state_d = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            // input is blocked here because in_ready_q is low
            if (pop) begin
               out_d   = skid_q;
               state_d = OCC_ONE;
            end
         end
         default: state_d = OCC_EMPTY;
      endcase
      // ready next cycle means the skid register will be empty
      in_ready_d = (state_d != OCC_FULL);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= OCC_EMPTY;
         out_q      <= ENTRY_RST;
         skid_q     <= ENTRY_RST;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = (state_q != OCC_EMPTY);
   assign IMM       = out_q.imm;
   assign TARGET    = out_q.target;
   assign FMT       = out_q.fmt;
   assign ILLEGAL   = out_q.ill;

endmodule
